// File: rtl/tx_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tx_frame_sequencer : frames a user byte stream (preamble, sync, length, payload, gap)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_frame_sequencer #(
  parameter int          SIZE_INPUT_BIT = 8,
  parameter int          PREAMBLE_LEN   = 4,
  parameter logic [7:0]  PREAMBLE_BYTE  = 8'hAA,
  parameter logic [7:0]  SYNC_BYTE      = 8'h7E,
  parameter int          MAX_PAYLOAD    = 64,
  parameter int          GAP_CYCLES     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [7:0]                i_length,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  input  logic [SIZE_INPUT_BIT-1:0] i_data,
  input  logic                      i_valid_input,
  output logic                      o_ready,
  output logic [SIZE_INPUT_BIT-1:0] o_data,
  output logic                      o_valid_output,
  input  logic                      i_ready_output
);

  // One counter serves preamble, payload and gap; it must span 255 and GAP_CYCLES-1.
  localparam int c_cnt_need = (GAP_CYCLES > 256) ? GAP_CYCLES : 256;
  localparam int c_cnt_w    = $clog2(c_cnt_need);

  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(PREAMBLE_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [7:0]         c_max_len  = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SYNC     = 3'd2,
    S_LENGTH   = 3'd3,
    S_PAYLOAD  = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [7:0]           r_len_q;
  logic                 r_done;
  logic                 r_error;

  logic                 w_xfer;
  logic                 w_len_ok;
  logic [c_cnt_w-1:0]   w_len_last;

  assign w_xfer     = o_valid_output & i_ready_output;
  assign w_len_ok   = (i_length != 8'd0) && (i_length <= c_max_len);
  assign w_len_last = c_cnt_w'(r_len_q) - c_one;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_len_q <= i_length;
              r_cnt   <= '0;
              r_state <= S_PREAMBLE;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_PREAMBLE: begin
          if (w_xfer) begin
            if (r_cnt == c_pre_last) begin
              r_cnt   <= '0;
              r_state <= S_SYNC;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        S_SYNC: begin
          if (w_xfer) r_state <= S_LENGTH;
        end
        S_LENGTH: begin
          if (w_xfer) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            if (r_cnt == w_len_last) begin
              r_cnt   <= '0;
              r_state <= S_GAP;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        S_GAP: begin
          // Counts plain clocks; the modulator is left idle regardless of its ready.
          if (r_cnt == c_gap_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data path is combinational so payload bytes pass through with zero latency.
  always_comb begin
    o_data         = '0;
    o_valid_output = 1'b0;
    o_ready        = 1'b0;
    case (r_state)
      S_PREAMBLE: begin
        o_data         = SIZE_INPUT_BIT'(PREAMBLE_BYTE);
        o_valid_output = 1'b1;
      end
      S_SYNC: begin
        o_data         = SIZE_INPUT_BIT'(SYNC_BYTE);
        o_valid_output = 1'b1;
      end
      S_LENGTH: begin
        o_data         = SIZE_INPUT_BIT'(r_len_q);
        o_valid_output = 1'b1;
      end
      S_PAYLOAD: begin
        o_data         = i_data;
        o_valid_output = i_valid_input;
        o_ready        = i_ready_output;
      end
      default: begin
        o_data         = '0;
        o_valid_output = 1'b0;
        o_ready        = 1'b0;
      end
    endcase
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_sequencer : randomized frames checked against a byte-queue frame model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tx_frame_sequencer;

  localparam int         c_pre_len  = 4;
  localparam logic [7:0] c_pre_byte = 8'hAA;
  localparam logic [7:0] c_sync     = 8'h7E;
  localparam int         c_max_pay  = 64;
  localparam int         c_gap      = 16;
  localparam int         c_hdr      = c_pre_len + 2;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_length;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [7:0] i_data;
  logic       i_valid_input;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid_output;
  logic       i_ready_output;

  int n_vec  = 0;
  int n_fail = 0;

  tx_frame_sequencer #(
    .SIZE_INPUT_BIT (8),
    .PREAMBLE_LEN   (c_pre_len),
    .PREAMBLE_BYTE  (c_pre_byte),
    .SYNC_BYTE      (c_sync),
    .MAX_PAYLOAD    (c_max_pay),
    .GAP_CYCLES     (c_gap)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_length       (i_length),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .i_data         (i_data),
    .i_valid_input  (i_valid_input),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_valid_output (o_valid_output),
    .i_ready_output (i_ready_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(o_busy),         32'd0);
    chk({tag, "_done"},  32'(o_done),         32'd0);
    chk({tag, "_error"}, 32'(o_error),        32'd0);
    chk({tag, "_valid"}, 32'(o_valid_output), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready),        32'd0);
    chk({tag, "_data"},  32'(o_data),         32'd0);
  endtask

  // Runs one frame from the first clock after the start was sampled.  The model
  // is the expected byte list: preamble, sync, length, then the source payload.
  task automatic run_frame(input int len, input int stall_pct, input int gap_pct,
                           input bit poke_start, input int abort_at, output int span);
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         src_idx   = 0;
    int         cyc       = 0;
    int         last_xfer = -1;
    int         total     = c_hdr + len;
    bit         done_seen = 1'b0;
    bit         aborted   = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    for (int i = 0; i < c_pre_len; i++) exp_q.push_back(c_pre_byte);
    exp_q.push_back(c_sync);
    exp_q.push_back(8'(len));
    foreach (pay[i]) exp_q.push_back(pay[i]);
    span = 0;

    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      i_start        = 1'b0;
      i_ready_output = ($urandom_range(99) >= 32'(stall_pct));
      i_valid_input  = ($urandom_range(99) >= 32'(gap_pct));
      i_data         = (src_idx < len) ? pay[src_idx] : 8'($urandom);
      if (poke_start && got.size() >= c_hdr && got.size() < total) begin
        i_start  = 1'b1;
        i_length = 8'd2;
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        i_reset        = 1'b1;
        i_ready_output = 1'b1;
        i_valid_input  = 1'b1;
        aborted        = 1'b1;
        break;
      end
      #1;
      cyc++;
      if (prev_stall)
        chk("stall_hold", {23'd0, o_valid_output, o_data}, {23'd0, 1'b1, prev_data});
      if (got.size() < c_hdr) begin
        chk("hdr_ready_low", 32'(o_ready), 32'd0);
      end else if (got.size() < total) begin
        chk("pay_valid_mirror", 32'(o_valid_output), 32'(i_valid_input));
        chk("pay_ready_mirror", 32'(o_ready), 32'(i_ready_output));
        if (i_valid_input) chk("pay_data", 32'(o_data), 32'(pay[src_idx]));
      end else begin
        chk("gap_quiet", {30'd0, o_valid_output, o_ready}, 32'd0);
      end
      prev_stall = (got.size() < c_hdr) && o_valid_output && !i_ready_output;
      prev_data  = o_data;
      if (i_valid_input && o_ready && src_idx < len) src_idx++;
      if (o_valid_output && i_ready_output) begin
        got.push_back(o_data);
        last_xfer = cyc;
      end
      if (o_done) begin
        done_seen = 1'b1;
        chk("done_after_gap", 32'(cyc - last_xfer), 32'(c_gap + 1));
        chk("done_busy_low", 32'(o_busy), 32'd0);
      end
    end

    if (aborted) begin
      @(negedge clk);
      i_reset = 1'b0;
      #1;
      chk_idle_outputs("abort");
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        #1;
        chk("abort_no_done", {30'd0, o_done, o_busy}, 32'd0);
      end
      return;
    end

    chk("frame_timeout", 32'(done_seen), 32'd1);
    span = cyc;
    chk("frame_bytes", 32'(got.size()), 32'(total));
    chk("user_bytes", 32'(src_idx), 32'(len));
    for (int i = 0; i < total && i < got.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic start_now(input int len);
    i_start  = 1'b1;
    i_length = 8'(len);
  endtask

  initial begin
    int span;
    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_length       = 8'd0;
    i_data         = 8'h55;
    i_valid_input  = 1'b1;
    i_ready_output = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    i_reset = 1'b0;

    // Basic frame, no back-pressure, source always valid: minimum duration.
    @(negedge clk);
    start_now(3);
    run_frame(3, 0, 0, 1'b0, -1, span);
    chk("min_duration", 32'(span), 32'(c_hdr + 3 + c_gap + 1));
    @(negedge clk);
    #1;
    chk("post_done", {30'd0, o_done, o_busy}, 32'd0);

    // Heavy output back-pressure, longest payload.
    @(negedge clk);
    start_now(c_max_pay);
    run_frame(c_max_pay, 50, 0, 1'b0, -1, span);

    // Source gaps during payload.
    @(negedge clk);
    start_now(5);
    run_frame(5, 0, 40, 1'b0, -1, span);

    // Illegal lengths: rejected with an error pulse, nothing emitted.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start_now((k == 0) ? 0 : c_max_pay + 1);
      @(negedge clk);
      i_start = 1'b0;
      #1;
      chk("err_pulse", {29'd0, o_error, o_busy, o_valid_output}, 32'h4);
      @(negedge clk);
      #1;
      chk("err_cleared", {29'd0, o_error, o_busy, o_valid_output}, 32'h0);
    end

    // Start pulsed during payload is ignored; start on the done clock chains a frame.
    @(negedge clk);
    start_now(6);
    run_frame(6, 20, 20, 1'b1, -1, span);
    start_now(3);
    run_frame(3, 0, 0, 1'b0, -1, span);
    chk("chained_duration", 32'(span), 32'(c_hdr + 3 + c_gap + 1));

    // Reset on the second payload byte, then a one-byte frame.
    @(negedge clk);
    start_now(4);
    run_frame(4, 0, 0, 1'b0, c_hdr + 1, span);
    @(negedge clk);
    start_now(1);
    run_frame(1, 0, 0, 1'b0, -1, span);
    chk("recover_duration", 32'(span), 32'(c_hdr + 1 + c_gap + 1));

    // A few extra random frames with mixed stalls and gaps.
    for (int k = 0; k < 4; k++) begin
      int len;
      len = 1 + int'($urandom_range(c_max_pay - 1));
      @(negedge clk);
      start_now(len);
      run_frame(len, 30, 30, 1'b0, -1, span);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
